// File: rtl/obstacle_scanner.sv
// obstacle_scanner: per-frame 4-direction obstacle scan for all players.
// Snapshots player positions on start, issues one map read per cycle
// (4 per player), tracks each read through a MEM_LATENCY-deep tag pipe,
// and publishes the assembled obstacle vector atomically with a done pulse.
module obstacle_scanner #(
  parameter int NUM_ROW     = 11,
  parameter int NUM_COL     = 19,
  parameter int TILE_SIZE   = 32,
  parameter int NUM_PLAYERS = 2,
  parameter int MEM_LATENCY = 1,
  localparam int ADDR_WIDTH = $clog2(NUM_ROW * NUM_COL)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [NUM_PLAYERS*11-1:0]  player_x,
  input  logic [NUM_PLAYERS*10-1:0]  player_y,
  output logic [ADDR_WIDTH-1:0]      map_addr,
  input  logic [1:0]                 map_rdata,
  output logic                       busy,
  output logic                       done,
  output logic [NUM_PLAYERS*4-1:0]   obstacles
);

  localparam int unsigned NLOOK = 4 * NUM_PLAYERS;
  localparam int unsigned KW    = $clog2(NLOOK + 1);
  localparam int unsigned IW    = $clog2(NLOOK);
  localparam int unsigned DW    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int unsigned SHIFT = $clog2(TILE_SIZE);
  localparam logic [10:0] XMASK = 11'(TILE_SIZE - 1);
  localparam logic [9:0]  YMASK = 10'(TILE_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_PUBLISH} state_t;

  state_t                      r_state;
  logic [NUM_PLAYERS*11-1:0]   r_snap_x;
  logic [NUM_PLAYERS*10-1:0]   r_snap_y;
  logic [KW-1:0]               r_k;
  logic [DW-1:0]               r_drain;
  logic [ADDR_WIDTH-1:0]       r_addr;
  logic                        r_busy;
  logic                        r_done;
  logic [NLOOK-1:0]            r_obstacles;
  logic [NLOOK-1:0]            r_shadow;

  // Issue-stage tag, aligned with the address currently on map_addr
  logic                        r_iss_v;
  logic [IW-1:0]               r_iss_k;
  logic                        r_iss_oob;
  logic                        r_iss_al;

  // Tag pipeline; stage MEM_LATENCY-1 lines up with map_rdata
  logic [MEM_LATENCY-1:0]      r_pv;
  logic [IW-1:0]               r_pk [MEM_LATENCY];
  logic [MEM_LATENCY-1:0]      r_poob;
  logic [MEM_LATENCY-1:0]      r_pal;

  logic [NUM_PLAYERS*11-1:0]   w_src_x;
  logic [NUM_PLAYERS*10-1:0]   w_src_y;
  logic [KW-1:0]               w_lk;
  logic [1:0]                  w_dir;
  logic [10:0]                 w_px;
  logic [9:0]                  w_py;
  logic [10:0]                 w_col;
  logic [9:0]                  w_row;
  logic [10:0]                 w_ncol;
  logic [9:0]                  w_nrow;
  logic                        w_edge;
  logic                        w_oob;
  logic                        w_aligned;
  logic [ADDR_WIDTH-1:0]       w_addr;
  logic [NLOOK-1:0]            w_shadow_next;

  // Lookup generation: in IDLE lookup 0 is computed from the live inputs so
  // its address can be registered on the same edge that accepts start.
  always_comb begin
    w_src_x = (r_state == S_IDLE) ? player_x : r_snap_x;
    w_src_y = (r_state == S_IDLE) ? player_y : r_snap_y;
    w_lk    = (r_state == S_IDLE) ? '0 : r_k;
    w_dir   = w_lk[1:0];
    w_px    = '0;
    w_py    = '0;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      if (32'(w_lk >> 2) == p) begin
        w_px = w_src_x[p*11 +: 11];
        w_py = w_src_y[p*10 +: 10];
      end
    end
    w_col     = w_px >> SHIFT;
    w_row     = w_py >> SHIFT;
    w_nrow    = w_row;
    w_ncol    = w_col;
    w_edge    = 1'b0;
    w_aligned = 1'b0;
    case (w_dir)
      2'd0: begin
        w_edge    = (w_row == '0);
        w_nrow    = w_row - 10'd1;
        w_aligned = ((w_py & YMASK) == '0);
      end
      2'd1: begin
        w_edge    = (w_row == 10'(NUM_ROW - 1));
        w_nrow    = w_row + 10'd1;
        w_aligned = ((w_py & YMASK) == YMASK);
      end
      2'd2: begin
        w_edge    = (w_col == '0);
        w_ncol    = w_col - 11'd1;
        w_aligned = ((w_px & XMASK) == '0);
      end
      2'd3: begin
        w_edge    = (w_col == 11'(NUM_COL - 1));
        w_ncol    = w_col + 11'd1;
        w_aligned = ((w_px & XMASK) == XMASK);
      end
      default: ;
    endcase
    w_oob  = w_edge || (w_row >= 10'(NUM_ROW)) || (w_col >= 11'(NUM_COL));
    w_addr = w_oob ? '0
                   : ADDR_WIDTH'(w_nrow) * ADDR_WIDTH'(NUM_COL) + ADDR_WIDTH'(w_ncol);
  end

  // Merge the returning read into the shadow vector; out-of-bounds is a wall
  always_comb begin
    w_shadow_next = r_shadow;
    if (r_pv[MEM_LATENCY-1]) begin
      w_shadow_next[r_pk[MEM_LATENCY-1]] =
        (r_poob[MEM_LATENCY-1] || (map_rdata != 2'b00)) && r_pal[MEM_LATENCY-1];
    end
  end

  // Scan FSM with registered address, status and published result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_snap_x    <= '0;
      r_snap_y    <= '0;
      r_k         <= '0;
      r_drain     <= '0;
      r_addr      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_obstacles <= '0;
      r_iss_v     <= 1'b0;
      r_iss_k     <= '0;
      r_iss_oob   <= 1'b0;
      r_iss_al    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_iss_v <= 1'b0;
          r_addr  <= '0;
          if (start) begin
            r_snap_x  <= player_x;
            r_snap_y  <= player_y;
            r_addr    <= w_addr;
            r_iss_v   <= 1'b1;
            r_iss_k   <= IW'(w_lk);
            r_iss_oob <= w_oob;
            r_iss_al  <= w_aligned;
            r_k       <= KW'(1);
            r_busy    <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_k == KW'(NLOOK)) begin
            r_addr  <= '0;
            r_iss_v <= 1'b0;
            r_drain <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_addr    <= w_addr;
            r_iss_v   <= 1'b1;
            r_iss_k   <= IW'(w_lk);
            r_iss_oob <= w_oob;
            r_iss_al  <= w_aligned;
            r_k       <= r_k + KW'(1);
          end
        end
        S_DRAIN: begin
          // Final read lands in the last drain cycle, so publish the merged value
          if (r_drain == DW'(MEM_LATENCY - 1)) begin
            r_obstacles <= w_shadow_next;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_PUBLISH;
          end else begin
            r_drain <= r_drain + DW'(1);
          end
        end
        S_PUBLISH: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag pipeline shift and shadow accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pv     <= '0;
      r_poob   <= '0;
      r_pal    <= '0;
      r_shadow <= '0;
      for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
        r_pk[i] <= '0;
      end
    end else begin
      r_shadow  <= w_shadow_next;
      r_pv[0]   <= r_iss_v;
      r_pk[0]   <= r_iss_k;
      r_poob[0] <= r_iss_oob;
      r_pal[0]  <= r_iss_al;
      for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
        r_pv[i]   <= r_pv[i-1];
        r_pk[i]   <= r_pk[i-1];
        r_poob[i] <= r_poob[i-1];
        r_pal[i]  <= r_pal[i-1];
      end
    end
  end

  assign map_addr  = r_addr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign obstacles = r_obstacles;

endmodule

// File: tb/tb_obstacle_scanner.sv
// Self-checking bench for obstacle_scanner: two instances (read latency 1
// and 3) share stimulus and a map memory; expectations come from a
// tile-arithmetic reference model.
module tb_obstacle_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [21:0] player_x;
  logic [19:0] player_y;
  logic [7:0]  addr_a, addr_b;
  logic [1:0]  rdata_a, rdata_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [7:0]  obst_a, obst_b;

  int errors;
  int checks;

  logic [1:0] mem [256];
  logic [1:0] ra;
  logic [1:0] rb [3];

  int         px [2];
  int         py [2];
  int         exp_addr [8];
  logic [7:0] exp_obst;
  logic [7:0] exp_prev;

  logic [7:0] h_addr_a [21];
  logic [7:0] h_addr_b [21];
  logic       h_busy_a [21];
  logic       h_busy_b [21];
  logic       h_done_a [21];
  logic       h_done_b [21];
  logic [7:0] h_obs_a  [21];
  logic [7:0] h_obs_b  [21];

  always #5 clk = ~clk;

  obstacle_scanner #(.MEM_LATENCY(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .player_x(player_x), .player_y(player_y),
    .map_addr(addr_a), .map_rdata(rdata_a), .busy(busy_a), .done(done_a), .obstacles(obst_a)
  );

  obstacle_scanner #(.MEM_LATENCY(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .player_x(player_x), .player_y(player_y),
    .map_addr(addr_b), .map_rdata(rdata_b), .busy(busy_b), .done(done_b), .obstacles(obst_b)
  );

  // Map RAMs with 1- and 3-cycle read latency
  always @(posedge clk) begin
    ra    <= mem[addr_a];
    rb[0] <= mem[addr_b];
    rb[1] <= rb[0];
    rb[2] <= rb[1];
  end
  assign rdata_a = ra;
  assign rdata_b = rb[2];

  // Reference: 4 lookups per player from tile coordinates, bounds and alignment
  function automatic void model();
    for (int k = 0; k < 8; k++) begin
      int p, d, col, row, nr, nc, xo, yo;
      bit oob, al, wall;
      p = k / 4; d = k % 4;
      col = px[p] / 32; row = py[p] / 32;
      xo = px[p] % 32; yo = py[p] % 32;
      nr = row; nc = col;
      oob = (row >= 11) || (col >= 19);
      al = 1'b0;
      case (d)
        0: begin if (row == 0) oob = 1'b1; else nr = row - 1; al = (yo == 0); end
        1: begin if (row >= 10) oob = 1'b1; else nr = row + 1; al = (yo == 31); end
        2: begin if (col == 0) oob = 1'b1; else nc = col - 1; al = (xo == 0); end
        default: begin if (col >= 18) oob = 1'b1; else nc = col + 1; al = (xo == 31); end
      endcase
      exp_addr[k] = oob ? 0 : nr * 19 + nc;
      wall = oob || (mem[exp_addr[k]] != 2'b00);
      exp_obst[k] = wall && al;
    end
  endfunction

  task automatic clear_map();
    for (int i = 0; i < 256; i++) mem[i] = 2'b00;
  endtask

  task automatic random_map();
    clear_map();
    for (int i = 0; i < 209; i++)
      if ($urandom_range(0, 9) < 3) mem[i] = 2'($urandom_range(1, 3));
  endtask

  task automatic rand_pos(output int x, output int y);
    int ox, oy;
    ox = $urandom_range(0, 3);
    oy = $urandom_range(0, 3);
    x = $urandom_range(0, 20) * 32 + ((ox == 0) ? 0 : (ox == 1) ? 31 : $urandom_range(0, 31));
    y = $urandom_range(0, 11) * 32 + ((oy == 0) ? 0 : (oy == 1) ? 31 : $urandom_range(0, 31));
  endtask

  // Drives one scan from a negedge and records both DUTs for cycles 1..20.
  // Player inputs are scrambled after the start edge to exercise the snapshot.
  task automatic scan(input int extra_start, input int rst_at);
    player_x = {11'(px[1]), 11'(px[0])};
    player_y = {10'(py[1]), 10'(py[0])};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      player_x = 22'($urandom);
      player_y = 20'($urandom);
      if (rst_at > 0 && c == rst_at) begin rst_n = 1'b0; #1; end
      if (rst_at > 0 && c == rst_at + 2) rst_n = 1'b1;
      h_addr_a[c] = addr_a; h_addr_b[c] = addr_b;
      h_busy_a[c] = busy_a; h_busy_b[c] = busy_b;
      h_done_a[c] = done_a; h_done_b[c] = done_b;
      h_obs_a[c]  = obst_a; h_obs_b[c]  = obst_b;
      start = (c == extra_start);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({addr_a, busy_a, done_a, obst_a} !== 18'd0) begin
      errors++; $display("FAIL reset_a got addr=%0d busy=%b done=%b obst=%b exp all 0", addr_a, busy_a, done_a, obst_a);
    end
    checks++;
    if ({addr_b, busy_b, done_b, obst_b} !== 18'd0) begin
      errors++; $display("FAIL reset_b got addr=%0d busy=%b done=%b obst=%b exp all 0", addr_b, busy_b, done_b, obst_b);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({addr_a, busy_a, done_a, obst_a} !== 18'd0) begin
      errors++; $display("FAIL idle_a got addr=%0d busy=%b done=%b obst=%b exp all 0", addr_a, busy_a, done_a, obst_a);
    end
    checks++;
    if ({addr_b, busy_b, done_b, obst_b} !== 18'd0) begin
      errors++; $display("FAIL idle_b got addr=%0d busy=%b done=%b obst=%b exp all 0", addr_b, busy_b, done_b, obst_b);
    end
    exp_prev = 8'd0;
  endtask

  task automatic test_single_wall();
    clear_map();
    mem[21] = 2'b01;
    px[0] = 64;  py[0] = 64;
    px[1] = 320; py[1] = 160;
    model();
    scan(0, 0);
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if (h_addr_a[c] !== 8'(exp_addr[c-1])) begin
        errors++; $display("FAIL sw_addr_a c=%0d got=%0d exp=%0d", c, h_addr_a[c], exp_addr[c-1]);
      end
      checks++;
      if (h_addr_b[c] !== 8'(exp_addr[c-1])) begin
        errors++; $display("FAIL sw_addr_b c=%0d got=%0d exp=%0d", c, h_addr_b[c], exp_addr[c-1]);
      end
    end
    checks++;
    if (h_addr_a[1] !== 8'd21 || h_addr_a[2] !== 8'd59 || h_addr_a[3] !== 8'd39 || h_addr_a[4] !== 8'd41) begin
      errors++; $display("FAIL sw_addr_seq got=%0d,%0d,%0d,%0d exp=21,59,39,41", h_addr_a[1], h_addr_a[2], h_addr_a[3], h_addr_a[4]);
    end
    for (int c = 1; c <= 20; c++) begin
      checks++;
      if (h_done_a[c] !== (c == 10)) begin
        errors++; $display("FAIL sw_done_a c=%0d got=%b exp=%b", c, h_done_a[c], (c == 10));
      end
      checks++;
      if (h_done_b[c] !== (c == 12)) begin
        errors++; $display("FAIL sw_done_b c=%0d got=%b exp=%b", c, h_done_b[c], (c == 12));
      end
    end
    checks++;
    if (h_obs_a[10][3:0] !== 4'b0001) begin
      errors++; $display("FAIL sw_p0_nibble got=%b exp=0001", h_obs_a[10][3:0]);
    end
    checks++;
    if (h_obs_a[10] !== exp_obst) begin
      errors++; $display("FAIL sw_obst_a got=%b exp=%b", h_obs_a[10], exp_obst);
    end
    checks++;
    if (h_obs_b[12] !== exp_obst) begin
      errors++; $display("FAIL sw_obst_b got=%b exp=%b", h_obs_b[12], exp_obst);
    end
    exp_prev = exp_obst;
  endtask

  task automatic test_all_walls();
    clear_map();
    mem[21] = 2'b01; mem[59] = 2'b10; mem[39] = 2'b11; mem[41] = 2'b01;
    px[0] = 64; py[0] = 64;
    rand_pos(px[1], py[1]);
    model();
    scan(0, 0);
    checks++;
    if (h_obs_a[10][3:0] !== 4'b0101) begin
      errors++; $display("FAIL aw_p0_nibble got=%b exp=0101", h_obs_a[10][3:0]);
    end
    checks++;
    if (h_obs_a[10] !== exp_obst) begin
      errors++; $display("FAIL aw_obst_a got=%b exp=%b", h_obs_a[10], exp_obst);
    end
    checks++;
    if (h_obs_b[12] !== exp_obst) begin
      errors++; $display("FAIL aw_obst_b got=%b exp=%b", h_obs_b[12], exp_obst);
    end
    exp_prev = exp_obst;
  endtask

  task automatic test_corner_oob();
    clear_map();
    px[0] = 160; py[0] = 96;
    px[1] = 0;   py[1] = 0;
    model();
    scan(0, 0);
    checks++;
    if (h_addr_a[5] !== 8'd0 || h_addr_a[7] !== 8'd0) begin
      errors++; $display("FAIL co_addr_a got up=%0d left=%0d exp 0,0", h_addr_a[5], h_addr_a[7]);
    end
    checks++;
    if (h_addr_b[5] !== 8'd0 || h_addr_b[7] !== 8'd0) begin
      errors++; $display("FAIL co_addr_b got up=%0d left=%0d exp 0,0", h_addr_b[5], h_addr_b[7]);
    end
    checks++;
    if (h_obs_a[10][7:4] !== 4'b0101) begin
      errors++; $display("FAIL co_p1_nibble got=%b exp=0101", h_obs_a[10][7:4]);
    end
    checks++;
    if (h_obs_b[12] !== exp_obst) begin
      errors++; $display("FAIL co_obst_b got=%b exp=%b", h_obs_b[12], exp_obst);
    end
    exp_prev = exp_obst;
  endtask

  task automatic test_offmap();
    random_map();
    px[0] = 700; py[0] = 64;
    rand_pos(px[1], py[1]);
    model();
    scan(0, 0);
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (h_addr_a[c] !== 8'd0 || h_addr_b[c] !== 8'd0) begin
        errors++; $display("FAIL om_addr c=%0d got a=%0d b=%0d exp 0", c, h_addr_a[c], h_addr_b[c]);
      end
    end
    checks++;
    if (h_obs_a[10] !== exp_obst) begin
      errors++; $display("FAIL om_obst_a got=%b exp=%b", h_obs_a[10], exp_obst);
    end
    checks++;
    if (h_obs_b[12] !== exp_obst) begin
      errors++; $display("FAIL om_obst_b got=%b exp=%b", h_obs_b[12], exp_obst);
    end
    exp_prev = exp_obst;
  endtask

  task automatic test_restart_ignored();
    int na, nb;
    random_map();
    rand_pos(px[0], py[0]);
    rand_pos(px[1], py[1]);
    model();
    scan(4, 0);
    na = 0; nb = 0;
    for (int c = 1; c <= 20; c++) begin
      if (h_done_a[c] === 1'b1) na++;
      if (h_done_b[c] === 1'b1) nb++;
    end
    checks++;
    if (na != 1 || h_done_a[10] !== 1'b1) begin
      errors++; $display("FAIL rs_done_a got pulses=%0d at10=%b exp 1 at cycle 10", na, h_done_a[10]);
    end
    checks++;
    if (nb != 1 || h_done_b[12] !== 1'b1) begin
      errors++; $display("FAIL rs_done_b got pulses=%0d at12=%b exp 1 at cycle 12", nb, h_done_b[12]);
    end
    checks++;
    if (h_obs_b[12] !== exp_obst) begin
      errors++; $display("FAIL rs_obst_b got=%b exp=%b", h_obs_b[12], exp_obst);
    end
    exp_prev = exp_obst;
  endtask

  task automatic test_back_to_back();
    random_map();
    rand_pos(px[0], py[0]);
    rand_pos(px[1], py[1]);
    model();
    scan(10, 0);
    for (int c = 11; c <= 20; c++) begin
      checks++;
      if (h_busy_a[c] !== 1'b0 || h_done_a[c] !== 1'b0 || h_addr_a[c] !== 8'd0) begin
        errors++; $display("FAIL bb_idle_a c=%0d got busy=%b done=%b addr=%0d exp 0,0,0", c, h_busy_a[c], h_done_a[c], h_addr_a[c]);
      end
    end
    for (int c = 13; c <= 20; c++) begin
      checks++;
      if (h_busy_b[c] !== 1'b0 || h_done_b[c] !== 1'b0) begin
        errors++; $display("FAIL bb_idle_b c=%0d got busy=%b done=%b exp 0,0", c, h_busy_b[c], h_done_b[c]);
      end
    end
    checks++;
    if (h_obs_a[20] !== exp_obst) begin
      errors++; $display("FAIL bb_obst_a got=%b exp=%b", h_obs_a[20], exp_obst);
    end
    exp_prev = exp_obst;
  endtask

  task automatic test_reset_midscan();
    random_map();
    rand_pos(px[0], py[0]);
    rand_pos(px[1], py[1]);
    model();
    scan(0, 5);
    for (int c = 5; c <= 20; c++) begin
      checks++;
      if ({h_busy_a[c], h_done_a[c], h_obs_a[c], h_addr_a[c]} !== 18'd0) begin
        errors++; $display("FAIL mr_a c=%0d got busy=%b done=%b obst=%b addr=%0d exp all 0", c, h_busy_a[c], h_done_a[c], h_obs_a[c], h_addr_a[c]);
      end
      checks++;
      if ({h_busy_b[c], h_done_b[c], h_obs_b[c], h_addr_b[c]} !== 18'd0) begin
        errors++; $display("FAIL mr_b c=%0d got busy=%b done=%b obst=%b addr=%0d exp all 0", c, h_busy_b[c], h_done_b[c], h_obs_b[c], h_addr_b[c]);
      end
    end
    exp_prev = 8'd0;
    random_map();
    rand_pos(px[0], py[0]);
    rand_pos(px[1], py[1]);
    model();
    scan(0, 0);
    checks++;
    if (h_done_a[10] !== 1'b1 || h_obs_a[10] !== exp_obst) begin
      errors++; $display("FAIL mr_fresh_a got done=%b obst=%b exp done=1 obst=%b", h_done_a[10], h_obs_a[10], exp_obst);
    end
    checks++;
    if (h_done_b[12] !== 1'b1 || h_obs_b[12] !== exp_obst) begin
      errors++; $display("FAIL mr_fresh_b got done=%b obst=%b exp done=1 obst=%b", h_done_b[12], h_obs_b[12], exp_obst);
    end
    exp_prev = exp_obst;
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      random_map();
      rand_pos(px[0], py[0]);
      rand_pos(px[1], py[1]);
      model();
      scan(0, 0);
      for (int c = 1; c <= 20; c++) begin
        checks++;
        if (h_addr_a[c] !== ((c <= 8) ? 8'(exp_addr[c-1]) : 8'd0)) begin
          errors++; $display("FAIL rnd_addr_a it=%0d c=%0d got=%0d exp=%0d", it, c, h_addr_a[c], (c <= 8) ? exp_addr[c-1] : 0);
        end
        checks++;
        if (h_addr_b[c] !== ((c <= 8) ? 8'(exp_addr[c-1]) : 8'd0)) begin
          errors++; $display("FAIL rnd_addr_b it=%0d c=%0d got=%0d exp=%0d", it, c, h_addr_b[c], (c <= 8) ? exp_addr[c-1] : 0);
        end
        checks++;
        if (h_done_a[c] !== (c == 10) || h_done_b[c] !== (c == 12)) begin
          errors++; $display("FAIL rnd_done it=%0d c=%0d got a=%b b=%b exp a=%b b=%b", it, c, h_done_a[c], h_done_b[c], (c == 10), (c == 12));
        end
        checks++;
        if (h_obs_a[c] !== ((c < 10) ? exp_prev : exp_obst)) begin
          errors++; $display("FAIL rnd_obst_a it=%0d c=%0d got=%b exp=%b", it, c, h_obs_a[c], (c < 10) ? exp_prev : exp_obst);
        end
        checks++;
        if (h_obs_b[c] !== ((c < 12) ? exp_prev : exp_obst)) begin
          errors++; $display("FAIL rnd_obst_b it=%0d c=%0d got=%b exp=%b", it, c, h_obs_b[c], (c < 12) ? exp_prev : exp_obst);
        end
        if (c != 10) begin
          checks++;
          if (h_busy_a[c] !== (c < 10)) begin
            errors++; $display("FAIL rnd_busy_a it=%0d c=%0d got=%b exp=%b", it, c, h_busy_a[c], (c < 10));
          end
        end
        if (c != 12) begin
          checks++;
          if (h_busy_b[c] !== (c < 12)) begin
            errors++; $display("FAIL rnd_busy_b it=%0d c=%0d got=%b exp=%b", it, c, h_busy_b[c], (c < 12));
          end
        end
      end
      exp_prev = exp_obst;
    end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    start    = 1'b0;
    player_x = '0;
    player_y = '0;
    rst_n    = 1'b0;
    exp_prev = 8'd0;
    clear_map();
    test_reset();
    test_single_wall();
    test_all_walls();
    test_corner_oob();
    test_offmap();
    test_restart_ignored();
    test_back_to_back();
    test_reset_midscan();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
